fp_acc_stream: RTL
==================

Name: fp_acc_stream

Overview:
- Sequential floating-point reduction stage that wraps the combinational fadd adder in the systolic-array datapath.
- Accepts a stream of `BIT_W-bit IEEE-format values over a valid/ready handshake and feeds each one to fadd together with its running sum.
- Registers fadd's result back into the accumulator, emitting one sum per vector, where a vector is a run of beats terminated by in_last.
- Consumes PE partial sums and feeds the writeback/output buffer.

Parameters:
- CNT_W, 8, width of the per-vector beat counter; saturates at 2^CNT_W-1.
- Data widths come from DEFINE_PKG macros `BIT_W, `EXP_W, `M_W and are not parameters.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  in_data/in_last valid
- in_ready  output  1  block can accept a beat
- in_data  input  `BIT_W  operand, IEEE format
- in_last  input  1  final beat of the current vector
- out_valid  output  1  out_* valid and held until taken
- out_ready  input  1  downstream accepts the result
- out_data  output  `BIT_W  accumulated sum
- out_count  output  CNT_W  beats in the vector (saturated)
- out_exc  output  1  sticky: some beat had exponent all-ones (Inf/NaN)
- out_mixed  output  1  sticky: some addition had opposite signs (fadd returns zero magnitude)

Behaviour:
- Reset is asynchronous, active-high, and takes effect immediately, including mid-vector or in HOLD; any partial sum is discarded.
  - State = IDLE; acc, out_data, out_count = 0.
  - out_valid, out_exc, out_mixed, the empty flag's complement, and all sticky flags = 0; empty = 1.
  - in_ready = 1 one cycle after rst deasserts; it is 0 while rst is high.
- FSM states:
  - IDLE: no vector open.
  - ACC: vector open, at least one beat taken.
  - HOLD: result presented, waiting for out_ready.
- Beat accept = in_valid & in_ready. in_ready = (state != HOLD) & ~rst.
- First beat of a vector (empty = 1): acc <= in_data directly, bypassing fadd, because fadd forces a hidden 1 and so cannot add zero correctly. Set empty = 0.
- Subsequent beats: acc <= fadd(acc, in_data). Exactly one fadd per beat; no combinational path from in_data to out_*.
- Flags per accepted beat:
  - out_exc sticky |= (&in_data[`BIT_W-2:`M_W]).
  - out_mixed sticky |= (~empty & (acc sign != in_data sign)).
  - fadd's own exception-to-zero result is still written to acc.
- Counter: cnt <= (first beat) ? 1 : sat_inc(cnt). It holds at all-ones on saturation.
- Accepted beat with in_last = 1:
  - The final sum, which is empty ? in_data : fadd(acc, in_data), loads out_data.
  - cnt loads out_count; the sticky flags load out_exc/out_mixed.
  - State -> HOLD; out_valid = 1 next cycle. Latency from last beat to out_valid is 1 cycle.
  - Internal acc, cnt, and sticky flags clear and empty = 1.
  - A single-beat vector outputs in_data unchanged with count 1.
- In HOLD:
  - out_* stay stable while out_valid & ~out_ready.
  - On out_valid & out_ready, out_valid drops the next cycle, state -> IDLE, and in_ready = 1 that cycle.
  - There is no same-cycle output-accept plus input-accept; there is a 1-cycle bubble per vector.
- IDLE -> ACC on an accepted beat with in_last = 0. ACC stays in ACC on in_last = 0 beats.
- in_valid = 0 mid-vector: hold all state indefinitely, with no timeout.
- in_data/in_last are ignored when in_ready = 0. The upstream must hold them; there is no overwrite.
- Signs: the result sign is the sign of the larger-magnitude operand, as fadd defines it; the block does not alter it.

Test Plan (BIT_W=32, EXP_W=8, M_W=23):
- 1.0, 2.0(last) = 0x3F800000, 0x40000000 -> out_data=0x40400000 (3.0), out_count=2, out_valid 1 cycle after last accept, flags 0.
- 3.0, 3.0(last) -> 0x40C00000 (6.0, carry path), count=2. Hold out_ready=0 for 5 cycles -> out_* stable and in_ready=0 throughout; then out_ready=1 -> IDLE, in_ready=1.
- Single beat 0xBF800000(last) -> out_data=0xBF800000, count=1. Then 2.0, -1.0(last) -> out_data=0x00000000, out_mixed=1.
- 0x7F800000, 1.0(last) -> out_exc=1, out_data=0x00000000. The next vector 1.0(last) -> out_exc=0 (flags are per vector).
- CNT_W=2, six beats of 1.0 with the last flagged -> out_count=3 (saturated).
- rst pulse mid-vector after 1.0, 2.0 -> out_valid=0 immediately. A new vector 4.0(last) -> out_data=0x40800000 with no residue.

Source files
------------

// File: rtl/fp_acc_stream.sv
// fp_acc_stream: streaming floating-point reduction around the fadd adder.
// Each vector (beats up to and including in_last) is summed into an
// accumulator and the total is presented on out_* until taken downstream.

`ifndef BIT_W
`define BIT_W 32
`endif
`ifndef EXP_W
`define EXP_W 8
`endif
`ifndef M_W
`define M_W 23
`endif

// Combinational same-sign adder: hidden 1 always forced, truncating,
// exponent all-ones operands give zero, opposite signs give zero magnitude.
module fadd (
   input  logic [`BIT_W-1:0] a_i,
   input  logic [`BIT_W-1:0] b_i,
   output logic [`BIT_W-1:0] sum_o
);
   localparam int BW = `BIT_W;
   localparam int EW = `EXP_W;
   localparam int MW = `M_W;

   logic          a_big;
   logic          s_big;
   logic          exc;
   logic          mixed;
   logic [EW-1:0] e_big;
   logic [EW-1:0] e_sml;
   logic [EW-1:0] e_diff;
   logic [EW-1:0] e_res;
   logic [MW:0]   m_big;
   logic [MW:0]   m_sml;
   logic [MW:0]   m_shf;
   logic [MW+1:0] m_sum;
   logic [MW-1:0] f_res;

   // Align the smaller operand, add mantissas, renormalise on carry-out.
   always_comb begin
      exc   = (&a_i[BW-2:MW]) | (&b_i[BW-2:MW]);
      mixed = a_i[BW-1] ^ b_i[BW-1];
      a_big = (a_i[BW-2:0] >= b_i[BW-2:0]);
      if (a_big) begin
         s_big = a_i[BW-1];
         e_big = a_i[BW-2:MW];
         m_big = {1'b1, a_i[MW-1:0]};
         e_sml = b_i[BW-2:MW];
         m_sml = {1'b1, b_i[MW-1:0]};
      end else begin
         s_big = b_i[BW-1];
         e_big = b_i[BW-2:MW];
         m_big = {1'b1, b_i[MW-1:0]};
         e_sml = a_i[BW-2:MW];
         m_sml = {1'b1, a_i[MW-1:0]};
      end
      e_diff = e_big - e_sml;
      m_shf  = m_sml >> e_diff;
      m_sum  = {1'b0, m_big} + {1'b0, m_shf};
      if (m_sum[MW+1]) begin
         e_res = e_big + EW'(1);
         f_res = m_sum[MW:1];
      end else begin
         e_res = e_big;
         f_res = m_sum[MW-1:0];
      end
      // Exponent overflow lands on infinity with a clean fraction.
      if (&e_res) begin
         f_res = '0;
      end
      if (exc) begin
         sum_o = '0;
      end else if (mixed) begin
         sum_o = {s_big, {(BW-1){1'b0}}};
      end else begin
         sum_o = {s_big, e_res, f_res};
      end
   end
endmodule

module fp_acc_stream #(
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [`BIT_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [`BIT_W-1:0] out_data,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_exc,
   output logic              out_mixed
);
   localparam int BW = `BIT_W;
   localparam int MW = `M_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t           state_q;
   logic [BW-1:0]    acc_q;
   logic [CNT_W-1:0] cnt_q;
   logic             empty_q;
   logic             exc_q;
   logic             mixed_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [BW-1:0]    out_data_q;
   logic [CNT_W-1:0] out_count_q;
   logic             out_exc_q;
   logic             out_mixed_q;

   logic             beat;
   logic [BW-1:0]    fsum;
   logic [BW-1:0]    sum_d;
   logic [CNT_W-1:0] cnt_d;
   logic             exc_d;
   logic             mixed_d;

   // Beat counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      if (&c) begin
         return c;
      end
      return c + CNT_W'(1);
   endfunction

   fadd u_fadd (
      .a_i   (acc_q),
      .b_i   (in_data),
      .sum_o (fsum)
   );

   assign beat = in_valid & in_ready_q;

   // Next accumulator/counter/flag values for the beat on the inputs; the
   // first beat bypasses fadd because fadd cannot add to a zero accumulator.
   always_comb begin
      sum_d   = empty_q ? in_data : fsum;
      cnt_d   = empty_q ? CNT_W'(1) : sat_inc(cnt_q);
      exc_d   = exc_q | (&in_data[BW-2:MW]);
      mixed_d = mixed_q | (~empty_q & (acc_q[BW-1] ^ in_data[BW-1]));
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         empty_q     <= 1'b1;
         exc_q       <= 1'b0;
         mixed_q     <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_count_q <= '0;
         out_exc_q   <= 1'b0;
         out_mixed_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE, ACC: begin
               in_ready_q <= 1'b1;
               if (beat) begin
                  if (in_last) begin
                     // Close the vector: publish the total and clear the
                     // accumulator so the next vector starts clean.
                     out_data_q  <= sum_d;
                     out_count_q <= cnt_d;
                     out_exc_q   <= exc_d;
                     out_mixed_q <= mixed_d;
                     out_valid_q <= 1'b1;
                     in_ready_q  <= 1'b0;
                     state_q     <= HOLD;
                     acc_q       <= '0;
                     cnt_q       <= '0;
                     exc_q       <= 1'b0;
                     mixed_q     <= 1'b0;
                     empty_q     <= 1'b1;
                  end else begin
                     acc_q   <= sum_d;
                     cnt_q   <= cnt_d;
                     exc_q   <= exc_d;
                     mixed_q <= mixed_d;
                     empty_q <= 1'b0;
                     state_q <= ACC;
                  end
               end
            end
            HOLD: begin
               // Input stays stalled until the result is taken, which
               // leaves a one-cycle bubble between vectors.
               if (out_valid_q && out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_count = out_count_q;
   assign out_exc   = out_exc_q;
   assign out_mixed = out_mixed_q;

endmodule
